// File: rtl/uart_link_pkg.sv
// Shared types and constants for the UART link sequencing controller.
package uart_link_pkg;

  typedef enum logic {R_HIGH, R_LOW} rx_state_t;
  typedef enum logic {T_IDLE, T_WAIT} tx_state_t;

  localparam int NUM_REQ = 2;

endpackage

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between two byte requesters.
module uart_tx_arb
  import uart_link_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] tx_req,
  input  logic [7:0]         tx_byte0,
  input  logic [7:0]         tx_byte1,
  input  logic               tx_done,
  output logic [NUM_REQ-1:0] tx_ack,
  output logic               trmt,
  output logic [7:0]         tx_data,
  output logic               tx_busy
);

  // Handshake: tx_req[i] is a valid held until the one-cycle tx_ack[i]; the ack
  // is the only acceptance, so a request still high after its ack is a new one.
  tx_state_t state;
  logic      ptr;
  logic      tx_done_q;
  logic      winner;
  logic      done_rise;

  assign winner    = tx_req[ptr] ? ptr : ~ptr;
  assign done_rise = tx_done & ~tx_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= T_IDLE;
      ptr       <= 1'b0;
      tx_done_q <= 1'b0;
      tx_ack    <= '0;
      trmt      <= 1'b0;
      tx_data   <= '0;
      tx_busy   <= 1'b0;
    end else begin
      tx_done_q <= tx_done;
      tx_ack    <= '0;
      trmt      <= 1'b0;
      case (state)
        T_IDLE: begin
          if (|tx_req) begin
            tx_ack[winner] <= 1'b1;
            tx_data        <= winner ? tx_byte1 : tx_byte0;
            trmt           <= 1'b1;
            tx_busy        <= 1'b1;
            ptr            <= ~winner;
            state          <= T_WAIT;
          end
        end
        T_WAIT: begin
          // Only a fresh rising edge ends the transfer; a level left high
          // from the previous byte must not complete this one.
          if (done_rise) begin
            tx_busy <= 1'b0;
            state   <= T_IDLE;
          end
        end
        default: state <= T_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_link_ctrl.sv
// UART link controller: assembles received byte pairs into 16-bit commands
// and arbitrates the shared transmitter between two requesters.
module uart_link_ctrl
  import uart_link_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_rdy,
  input  logic [7:0]         rx_data,
  output logic               clr_rx_rdy,
  output logic [15:0]        cmd,
  output logic               cmd_rdy,
  input  logic               clr_cmd_rdy,
  output logic               cmd_ovr,
  input  logic [NUM_REQ-1:0] tx_req,
  input  logic [7:0]         tx_byte0,
  input  logic [7:0]         tx_byte1,
  output logic [NUM_REQ-1:0] tx_ack,
  output logic               trmt,
  output logic [7:0]         tx_data,
  input  logic               tx_done,
  output logic               tx_busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  // Handshake: cmd_rdy is a valid held until the consumer pulses clr_cmd_rdy;
  // a new assembly in the same cycle as the clear wins and keeps cmd_rdy high.
  rx_state_t       rx_state;
  logic [7:0]      high_byte;
  logic [TO_W-1:0] to_cnt;
  logic            rx_take;

  // The UART needs a cycle to drop rx_rdy after a clear, so skip that cycle.
  assign rx_take = rx_rdy & ~clr_rx_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= R_HIGH;
      high_byte  <= '0;
      to_cnt     <= '0;
      clr_rx_rdy <= 1'b0;
      cmd        <= '0;
      cmd_rdy    <= 1'b0;
      cmd_ovr    <= 1'b0;
    end else begin
      clr_rx_rdy <= 1'b0;
      cmd_ovr    <= 1'b0;
      if (clr_cmd_rdy) cmd_rdy <= 1'b0;
      case (rx_state)
        R_HIGH: begin
          if (rx_take) begin
            high_byte  <= rx_data;
            clr_rx_rdy <= 1'b1;
            to_cnt     <= '0;
            rx_state   <= R_LOW;
          end
        end
        R_LOW: begin
          if (rx_take) begin
            cmd        <= {high_byte, rx_data};
            cmd_rdy    <= 1'b1;
            cmd_ovr    <= cmd_rdy & ~clr_cmd_rdy;
            clr_rx_rdy <= 1'b1;
            rx_state   <= R_HIGH;
          end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            // Stale high byte: drop it and resynchronise on the next byte.
            to_cnt   <= '0;
            rx_state <= R_HIGH;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: rx_state <= R_HIGH;
      endcase
    end
  end

  uart_tx_arb u_tx_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_req   (tx_req),
    .tx_byte0 (tx_byte0),
    .tx_byte1 (tx_byte1),
    .tx_done  (tx_done),
    .tx_ack   (tx_ack),
    .trmt     (trmt),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
  );

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Self-checking bench for uart_link_ctrl: directed RX/TX sequences, a
// round-robin vector table and randomized traffic against a behavioural model.
module tb_uart_link_ctrl;

  localparam int TO = 150;

  logic        clk;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        cmd_ovr;
  logic [1:0]  tx_req;
  logic [7:0]  tx_byte0;
  logic [7:0]  tx_byte1;
  logic [1:0]  tx_ack;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        tx_busy;

  int n_cmp;
  int n_bad;
  int clr_cnt;
  int clr_consec;
  int ovr_cnt;
  logic clr_prev;

  logic [15:0] exp_q[$];
  logic [7:0]  exp_tx_q[$];

  typedef struct {
    logic [1:0] req;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [1:0] exp_ack;
    logic [7:0] exp_data;
  } tx_vec_t;

  tx_vec_t tbl[9];

  uart_link_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cmd_ovr     (cmd_ovr),
    .tx_req      (tx_req),
    .tx_byte0    (tx_byte0),
    .tx_byte1    (tx_byte1),
    .tx_ack      (tx_ack),
    .trmt        (trmt),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .tx_busy     (tx_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // pulse monitors
  initial begin
    clr_cnt = 0; clr_consec = 0; ovr_cnt = 0; clr_prev = 1'b0;
  end
  always @(negedge clk) begin
    if (clr_rx_rdy) clr_cnt++;
    if (clr_rx_rdy && clr_prev) clr_consec++;
    clr_prev = clr_rx_rdy;
    if (cmd_ovr) ovr_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_rdy = 1'b0; rx_data = '0; clr_cmd_rdy = 1'b0;
    tx_req = '0; tx_byte0 = '0; tx_byte1 = '0; tx_done = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    logic got;
    got = 1'b0;
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (clr_rx_rdy) got = 1'b1;
    end
    rx_rdy = 1'b0;
    if (!got) check("rx_accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic clear_cmd();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    check("cmd_rdy_cleared", 32'(cmd_rdy), 32'd0);
  endtask

  task automatic wait_grant(output logic [1:0] ack, output logic [7:0] data);
    logic got;
    got = 1'b0;
    ack = '0;
    data = '0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (trmt) begin
        got = 1'b1;
        ack = tx_ack;
        data = tx_data;
      end
    end
    if (!got) check("tx_grant_timeout", 32'(got), 32'd1);
  endtask

  task automatic tx_complete();
    check("tx_busy_before_done", 32'(tx_busy), 32'd1);
    tx_done = 1'b0;
    tick();
    tx_done = 1'b1;
    tick();
    check("tx_busy_after_done", 32'(tx_busy), 32'd0);
    tx_done = 1'b0;
  endtask

  initial begin
    logic [1:0]  ack;
    logic [7:0]  data;
    logic [7:0]  hi;
    logic        pending;
    int          start;
    int          idle;
    logic        long_gap;
    logic [7:0]  b;
    int          last_served;
    int          win;
    logic [1:0]  req;

    n_cmp = 0;
    n_bad = 0;

    tbl[0] = '{2'b01, 8'h10, 8'h20, 2'b01, 8'h10};
    tbl[1] = '{2'b01, 8'h11, 8'h21, 2'b01, 8'h11};
    tbl[2] = '{2'b11, 8'h12, 8'h22, 2'b10, 8'h22};
    tbl[3] = '{2'b11, 8'h13, 8'h23, 2'b01, 8'h13};
    tbl[4] = '{2'b10, 8'h14, 8'h24, 2'b10, 8'h24};
    tbl[5] = '{2'b10, 8'h15, 8'h25, 2'b10, 8'h25};
    tbl[6] = '{2'b11, 8'h16, 8'h26, 2'b01, 8'h16};
    tbl[7] = '{2'b01, 8'h17, 8'h27, 2'b01, 8'h17};
    tbl[8] = '{2'b11, 8'h18, 8'h28, 2'b10, 8'h28};

    // reset values while rst_n is held low
    rst_n = 1'b0;
    rx_rdy = 1'b0; rx_data = '0; clr_cmd_rdy = 1'b0;
    tx_req = '0; tx_byte0 = '0; tx_byte1 = '0; tx_done = 1'b0;
    tick(); tick();
    check("rst_clr_rx_rdy", 32'(clr_rx_rdy), 32'd0);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("rst_cmd_ovr", 32'(cmd_ovr), 32'd0);
    check("rst_tx_ack", 32'(tx_ack), 32'd0);
    check("rst_trmt", 32'(trmt), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // two bytes 100 cycles apart
    start = clr_cnt;
    send_byte(8'hA5);
    check("pair_no_early_cmd", 32'(cmd_rdy), 32'd0);
    repeat (100) tick();
    send_byte(8'h3C);
    check("pair_cmd_rdy", 32'(cmd_rdy), 32'd1);
    check("pair_cmd", 32'(cmd), 32'hA53C);
    repeat (3) tick();
    check("pair_clr_count", 32'(clr_cnt - start), 32'd2);
    clear_cmd();

    // stale high byte dropped after the timeout
    send_byte(8'h12);
    repeat (TO + 10) tick();
    send_byte(8'h34);
    check("to_no_cmd_after_34", 32'(cmd_rdy), 32'd0);
    send_byte(8'h56);
    check("to_cmd_rdy", 32'(cmd_rdy), 32'd1);
    check("to_cmd", 32'(cmd), 32'h3456);
    clear_cmd();

    // overwrite and simultaneous set/clear
    start = ovr_cnt;
    send_byte(8'h11); send_byte(8'h11);
    check("ovr_first_cmd", 32'(cmd), 32'h1111);
    send_byte(8'h22); send_byte(8'h22);
    check("ovr_pulse_now", 32'(cmd_ovr), 32'd1);
    check("ovr_cmd", 32'(cmd), 32'h2222);
    send_byte(8'h33);
    tick();
    rx_data = 8'h33; rx_rdy = 1'b1; clr_cmd_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
    check("setclr_accept", 32'(clr_rx_rdy), 32'd1);
    check("setclr_cmd_rdy", 32'(cmd_rdy), 32'd1);
    check("setclr_cmd", 32'(cmd), 32'h3333);
    repeat (3) tick();
    check("ovr_pulse_count", 32'(ovr_cnt - start), 32'd1);
    clear_cmd();

    // randomized RX traffic against the pairing/timeout model
    pending = 1'b0;
    hi = '0;
    for (int i = 0; i < 30; i++) begin
      b = 8'($urandom_range(0, 255));
      long_gap = ($urandom_range(0, 4) == 0);
      idle = long_gap ? (TO + 10 + int'($urandom_range(0, 20))) : int'($urandom_range(0, 15));
      repeat (idle) tick();
      if (long_gap) pending = 1'b0;
      if (pending) exp_q.push_back({hi, b});
      send_byte(b);
      if (pending) begin
        check("rnd_rx_cmd_rdy", 32'(cmd_rdy), 32'd1);
        check("rnd_rx_cmd", 32'(cmd), 32'(exp_q.pop_front()));
        clear_cmd();
        pending = 1'b0;
      end else begin
        check("rnd_rx_no_cmd", 32'(cmd_rdy), 32'd0);
        hi = b;
        pending = 1'b1;
      end
    end

    // round-robin vector table from a fresh pointer
    do_reset();
    foreach (tbl[i]) begin
      tx_req = tbl[i].req; tx_byte0 = tbl[i].b0; tx_byte1 = tbl[i].b1;
      wait_grant(ack, data);
      tx_req = '0;
      check("tbl_ack", 32'(ack), 32'(tbl[i].exp_ack));
      check("tbl_data", 32'(data), 32'(tbl[i].exp_data));
      tick();
      tx_complete();
    end

    // both requesters held high: strict alternation, one grant per tx_done
    do_reset();
    tx_req = 2'b11; tx_byte0 = 8'h41; tx_byte1 = 8'h42;
    exp_tx_q = '{8'h41, 8'h42, 8'h41, 8'h42};
    for (int i = 0; i < 4; i++) begin
      wait_grant(ack, data);
      check("hold_order", 32'(data), 32'(exp_tx_q.pop_front()));
      for (int k = 0; k < 3; k++) begin
        tick();
        check("hold_no_trmt_in_wait", 32'(trmt), 32'd0);
      end
      tx_complete();
    end
    tx_req = '0;
    tick();

    // tx_done already high at grant must not complete the transfer
    tx_done = 1'b1;
    tick(); tick();
    tx_req = 2'b10; tx_byte1 = 8'h7E;
    wait_grant(ack, data);
    tx_req = '0;
    check("donehi_ack", 32'(ack), 32'b10);
    check("donehi_data", 32'(data), 32'h7E);
    repeat (5) tick();
    check("donehi_busy_held", 32'(tx_busy), 32'd1);
    tx_done = 1'b0;
    tick(); tick();
    check("donehi_busy_low_done", 32'(tx_busy), 32'd1);
    check("donehi_data_stable", 32'(tx_data), 32'h7E);
    tx_done = 1'b1;
    tick();
    check("donehi_busy_cleared", 32'(tx_busy), 32'd0);
    tx_done = 1'b0;

    // randomized TX traffic against an alternate-when-contended model
    do_reset();
    last_served = 1;
    for (int i = 0; i < 24; i++) begin
      req = 2'($urandom_range(1, 3));
      tx_byte0 = 8'($urandom_range(0, 255));
      tx_byte1 = 8'($urandom_range(0, 255));
      if (req == 2'b11) win = (last_served == 0) ? 1 : 0;
      else win = (req == 2'b01) ? 0 : 1;
      last_served = win;
      tx_req = req;
      wait_grant(ack, data);
      tx_req = '0;
      check("rnd_tx_ack", 32'(ack), 32'(2'b01 << win));
      check("rnd_tx_data", 32'(data), 32'((win == 1) ? tx_byte1 : tx_byte0));
      repeat ($urandom_range(0, 3)) tick();
      tx_complete();
    end

    // asynchronous reset with RX in R_LOW and TX in T_WAIT
    send_byte(8'h9A); send_byte(8'hBC);
    send_byte(8'h55);
    tx_req = 2'b01; tx_byte0 = 8'h66;
    wait_grant(ack, data);
    tx_req = '0;
    check("pre_rst_busy", 32'(tx_busy), 32'd1);
    check("pre_rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_cmd", 32'(cmd), 32'd0);
    check("async_rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("async_rst_tx_busy", 32'(tx_busy), 32'd0);
    check("async_rst_tx_data", 32'(tx_data), 32'd0);
    check("async_rst_tx_ack", 32'(tx_ack), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tx_req = 2'b10; tx_byte1 = 8'h99;
    wait_grant(ack, data);
    tx_req = '0;
    check("post_rst_ack", 32'(ack), 32'b10);
    check("post_rst_data", 32'(data), 32'h99);
    tick();
    tx_complete();
    send_byte(8'h77);
    check("post_rst_partial_lost", 32'(cmd_rdy), 32'd0);
    send_byte(8'h88);
    check("post_rst_cmd", 32'(cmd), 32'h7788);

    tick();
    check("clr_rx_rdy_never_back_to_back", 32'(clr_consec), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
